unified_mem_ctrl: RTL and testbench

- Parametrised successor to the single-cycle shared instruction/data memory.
- Holds one unified 2^ADDR_W × DATA_W array with a registered instruction-fetch port (with immediate prefetch) and a registered data load/store port.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request, and same-cycle write-to-fetch forwarding.
- Sits between the fetch/memory pipeline stages and replaces the combinational memory.

---
 rtl/unified_mem_ctrl_if.sv | 30 +++
 rtl/unified_mem_ctrl.sv | 116 +++++++++++
 tb/tb_unified_mem_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_ctrl_if.sv
// rtl/unified_mem_ctrl_if.sv - fetch/data/clear request and response bundle for unified_mem_ctrl
interface unified_mem_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              clear_req;
    logic              ready;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] instr_out;
    logic [DATA_W-1:0] immediate;
    logic              imm_en;
    logic              if_valid;
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_rvalid;

    modport master (
        output clear_req, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        input  ready, instr_out, immediate, imm_en, if_valid, d_rdata, d_rvalid
    );

    modport slave (
        input  clear_req, if_req, if_addr, d_req, d_we, d_addr, d_wdata,
        output ready, instr_out, immediate, imm_en, if_valid, d_rdata, d_rvalid
    );
endinterface

// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - unified instr/data memory with clear sequencer; UNIFIED_MEM_WR_FWD_EN enables store-to-fetch forwarding
module unified_mem_ctrl #(
    parameter int         DATA_W     = 8,
    parameter int         ADDR_W     = 8,
    parameter logic [3:0] IMM_OPCODE = 4'hC
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_ctrl_if.slave      bus
);
    typedef enum logic {S_CLEAR, S_READY} state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state, w_state_nx;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nx;
    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    logic [DATA_W-1:0] r_instr, r_imm, r_rdata;
    logic              r_imm_en, r_if_valid, r_rvalid;

    logic              w_ready, w_accept, w_fetch, w_load, w_store, w_clr_we;
    logic [ADDR_W-1:0] w_if_addr_p1;
    logic [DATA_W-1:0] w_instr, w_imm_word;
    logic              w_imm_en;

    assign w_ready      = (r_state == S_READY);
    assign w_accept     = w_ready && !bus.clear_req;
    assign w_fetch      = w_accept && bus.if_req;
    assign w_load       = w_accept && bus.d_req && !bus.d_we;
    assign w_store      = w_accept && bus.d_req && bus.d_we;
    // rst gates the clear write so the array is untouched while reset is held
    assign w_clr_we     = (r_state == S_CLEAR) && rst;
    assign w_if_addr_p1 = bus.if_addr + ADDR_ONE;

`ifdef UNIFIED_MEM_WR_FWD_EN
    assign w_instr    = (w_store && bus.d_addr == bus.if_addr) ? bus.d_wdata : r_mem[bus.if_addr];
    assign w_imm_word = (w_store && bus.d_addr == w_if_addr_p1) ? bus.d_wdata : r_mem[w_if_addr_p1];
`else
    assign w_instr    = r_mem[bus.if_addr];
    assign w_imm_word = r_mem[w_if_addr_p1];
`endif

    assign w_imm_en = (w_instr[DATA_W-1 -: 4] == IMM_OPCODE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_ptr   <= w_ptr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        case (r_state)
            S_CLEAR: begin
                w_ptr_nx = r_ptr + ADDR_ONE;
                if (&r_ptr) begin
                    w_state_nx = S_READY;
                end
            end
            S_READY: begin
                if (bus.clear_req) begin
                    w_state_nx = S_CLEAR;
                    w_ptr_nx   = '0;
                end
            end
            default: begin
                w_state_nx = S_CLEAR;
                w_ptr_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[r_ptr] <= '0;
        end else if (w_store) begin
            r_mem[bus.d_addr] <= bus.d_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr    <= '0;
            r_imm      <= '0;
            r_imm_en   <= 1'b0;
            r_if_valid <= 1'b0;
            r_rdata    <= '0;
            r_rvalid   <= 1'b0;
        end else begin
            r_if_valid <= w_fetch;
            r_rvalid   <= w_load;
            if (w_fetch) begin
                r_instr  <= w_instr;
                r_imm_en <= w_imm_en;
                r_imm    <= w_imm_en ? w_imm_word : '0;
            end
            if (w_load) begin
                r_rdata <= r_mem[bus.d_addr];
            end
        end
    end

    assign bus.ready     = w_ready;
    assign bus.instr_out = r_instr;
    assign bus.immediate = r_imm;
    assign bus.imm_en    = r_imm_en;
    assign bus.if_valid  = r_if_valid;
    assign bus.d_rdata   = r_rdata;
    assign bus.d_rvalid  = r_rvalid;
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb/tb_unified_mem_ctrl.sv - directed self-checking bench for unified_mem_ctrl
module tb_unified_mem_ctrl;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    unified_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    unified_mem_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .IMM_OPCODE(4'hC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.clear_req = 1'b0;
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
    endtask

    task automatic store(input logic [7:0] a, input logic [7:0] d);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = a; bus.d_wdata = d;
        tick();
        idle();
    endtask

    task automatic fetch(input logic [7:0] a);
        bus.if_req = 1'b1; bus.if_addr = a;
        tick();
        idle();
    endtask

    task automatic load(input logic [7:0] a);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = a;
        tick();
        idle();
    endtask

    task automatic wait_ready(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (bus.ready !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, n, exp_cycles);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"},  bus.ready,     0);
        check({tag, "_ifv"},    bus.if_valid,  0);
        check({tag, "_rv"},     bus.d_rvalid,  0);
        check({tag, "_instr"},  bus.instr_out, 0);
        check({tag, "_imm"},    bus.immediate, 0);
        check({tag, "_immen"},  bus.imm_en,    0);
        check({tag, "_rdata"},  bus.d_rdata,   0);
    endtask

    initial begin
        idle();
        #12;
        check_all_zero("rst");

        rst = 1'b1;
        wait_ready("clear_len_boot", 256);

        fetch(8'h37);
        check("blank_instr", bus.instr_out, 0);
        check("blank_immen", bus.imm_en, 0);
        check("blank_ifv", bus.if_valid, 1);

        store(8'h10, 8'hC3);
        check("store_no_ifv", bus.if_valid, 0);
        store(8'h11, 8'h5A);
        fetch(8'h10);
        check("imm_instr", bus.instr_out, 8'hC3);
        check("imm_immen", bus.imm_en, 1);
        check("imm_val", bus.immediate, 8'h5A);
        check("imm_ifv", bus.if_valid, 1);
        tick();
        check("ifv_pulse", bus.if_valid, 0);
        check("instr_hold", bus.instr_out, 8'hC3);

        store(8'hFF, 8'hC0);
        store(8'h00, 8'h77);
        fetch(8'hFF);
        check("wrap_instr", bus.instr_out, 8'hC0);
        check("wrap_imm", bus.immediate, 8'h77);

        store(8'h30, 8'h20);
        fetch(8'h30);
        check("noimm_immen", bus.imm_en, 0);
        check("noimm_imm", bus.immediate, 0);

        load(8'h11);
        check("load_data", bus.d_rdata, 8'h5A);
        check("load_rv", bus.d_rvalid, 1);
        store(8'h12, 8'h99);
        check("store_no_rv", bus.d_rvalid, 0);
        check("store_rdata_hold", bus.d_rdata, 8'h5A);

        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h40; bus.d_wdata = 8'hC1;
        bus.if_req = 1'b1; bus.if_addr = 8'h40;
        tick();
        idle();
`ifdef UNIFIED_MEM_WR_FWD_EN
        check("fwd_instr", bus.instr_out, 8'hC1);
        check("fwd_immen", bus.imm_en, 1);
`else
        check("fwd_instr", bus.instr_out, 8'h00);
        check("fwd_immen", bus.imm_en, 0);
`endif
        fetch(8'h40);
        check("fwd_later", bus.instr_out, 8'hC1);
        check("fwd_later_imm", bus.immediate, 0);

        store(8'h60, 8'hC2);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 8'h61; bus.d_wdata = 8'h44;
        bus.if_req = 1'b1; bus.if_addr = 8'h60;
        tick();
        idle();
`ifdef UNIFIED_MEM_WR_FWD_EN
        check("fwd_imm", bus.immediate, 8'h44);
`else
        check("fwd_imm", bus.immediate, 8'h00);
`endif

        bus.if_req = 1'b1; bus.if_addr = 8'h10;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h30;
        tick();
        idle();
        check("dual_ifv", bus.if_valid, 1);
        check("dual_rv", bus.d_rvalid, 1);
        check("dual_instr", bus.instr_out, 8'hC3);
        check("dual_rdata", bus.d_rdata, 8'h20);

        bus.clear_req = 1'b1; bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 8'h10;
        tick();
        idle();
        check("clr_no_rv", bus.d_rvalid, 0);
        check("clr_ready", bus.ready, 0);
        check("clr_rdata_hold", bus.d_rdata, 8'h20);
        wait_ready("clear_len_req", 256);
        load(8'h10);
        check("clr_load", bus.d_rdata, 0);
        check("clr_load_rv", bus.d_rvalid, 1);

        store(8'h10, 8'hC3);
        store(8'h11, 8'h5A);
        fetch(8'h10);
        load(8'h11);
        check("pre_rst_imm", bus.immediate, 8'h5A);
        bus.clear_req = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 100; i++) tick();
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midclr_rst");
        tick();
        rst = 1'b1;
        wait_ready("clear_len_rst", 256);
        fetch(8'h10);
        check("post_rst_instr", bus.instr_out, 0);
        check("post_rst_immen", bus.imm_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
